// File: rtl/bus_grant_decoder_if.sv
// rtl/bus_grant_decoder_if.sv - request/burst/grant signal bundle for bus_grant_decoder
interface bus_grant_decoder_if;
    logic        req_valid_i;
    logic [4:0]  req_code_i;
    logic        req_ready_o;
    logic        release_i;
    logic        burst_load_i;
    logic [31:0] burst_mask_i;
    logic [31:0] grant_o;
    logic [4:0]  grant_code_o;
    logic        busy_o;
    logic        burst_done_o;

    modport slave (
        input  req_valid_i, req_code_i, release_i, burst_load_i, burst_mask_i,
        output req_ready_o, grant_o, grant_code_o, busy_o, burst_done_o
    );

    modport master (
        output req_valid_i, req_code_i, release_i, burst_load_i, burst_mask_i,
        input  req_ready_o, grant_o, grant_code_o, busy_o, burst_done_o
    );
endinterface

// File: rtl/bus_grant_decoder.sv
// rtl/bus_grant_decoder.sv - registered 5-to-32 one-hot grant decoder with burst walk; BUS_GRANT_GAP_EN adds break-before-make GAP
module bus_grant_decoder (
    input  logic                 clk,
    input  logic                 clr,
    bus_grant_decoder_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2,
        S_BURST = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] grant_q, grant_d;
    logic [4:0]  gcode_q, gcode_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] burst_src;
    logic [4:0]  low_idx;
    logic [31:0] low_bit;
    logic [31:0] burst_rest;

    function automatic logic [4:0] lowest_set(input logic [31:0] m);
        lowest_set = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) lowest_set = i[4:0];
        end
    endfunction

    // One priority picker serves both burst start (fresh mask) and burst continuation.
    assign burst_src  = (state_q == S_IDLE) ? bus.burst_mask_i : mask_q;
    assign low_idx    = lowest_set(burst_src);
    assign low_bit    = 32'h1 << low_idx;
    assign burst_rest = burst_src & ~low_bit;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        mask_d  = mask_q;
        grant_d = 32'h0;
        gcode_d = 5'd0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.burst_load_i) begin
                    if (bus.burst_mask_i == 32'h0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_BURST;
                        mask_d  = burst_rest;
                        grant_d = low_bit;
                        gcode_d = low_idx;
                        done_d  = (burst_rest == 32'h0);
                    end
                end else if (bus.req_valid_i) begin
                    state_d = S_DRIVE;
                    code_d  = bus.req_code_i;
                    grant_d = 32'h1 << bus.req_code_i;
                    gcode_d = bus.req_code_i;
                end
            end
            S_DRIVE: begin
                grant_d = 32'h1 << code_q;
                gcode_d = code_q;
                if (bus.req_valid_i && (bus.req_code_i != code_q)) begin
                    code_d = bus.req_code_i;
`ifdef BUS_GRANT_GAP_EN
                    state_d = S_GAP;
                    grant_d = 32'h0;
                    gcode_d = 5'd0;
`else
                    grant_d = 32'h1 << bus.req_code_i;
                    gcode_d = bus.req_code_i;
`endif
                end else if (!bus.req_valid_i && bus.release_i) begin
                    state_d = S_IDLE;
                    grant_d = 32'h0;
                    gcode_d = 5'd0;
                end
            end
            S_GAP: begin
                state_d = S_DRIVE;
                grant_d = 32'h1 << code_q;
                gcode_d = code_q;
            end
            S_BURST: begin
                if (mask_q == 32'h0) begin
                    state_d = S_IDLE;
                end else begin
                    mask_d  = burst_rest;
                    grant_d = low_bit;
                    gcode_d = low_idx;
                    done_d  = (burst_rest == 32'h0);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            code_q  <= 5'd0;
            mask_q  <= 32'h0;
            grant_q <= 32'h0;
            gcode_q <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            mask_q  <= mask_d;
            grant_q <= grant_d;
            gcode_q <= gcode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_ready_o  = (state_q == S_IDLE) || (state_q == S_DRIVE);
    assign bus.grant_o      = grant_q;
    assign bus.grant_code_o = gcode_q;
    assign bus.busy_o       = busy_q;
    assign bus.burst_done_o = done_q;

endmodule

// File: tb/tb_bus_grant_decoder.sv
// tb/tb_bus_grant_decoder.sv - scoreboard bench for bus_grant_decoder, directed cases then randomised model check
module tb_bus_grant_decoder;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    bus_grant_decoder_if bus_if();

    bus_grant_decoder dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    typedef struct packed {
        logic [31:0] grant;
        logic [4:0]  code;
        logic        busy;
        logic        done;
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int          m_st;
    logic [4:0]  m_code;
    logic [31:0] m_mask;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] g, input logic [4:0] c,
                                input logic b, input logic d, input logic r);
        exp_t e;
        e.grant = g; e.code = c; e.busy = b; e.done = d; e.ready = r;
        return e;
    endfunction

    function automatic logic [4:0] encode(input logic [31:0] g);
        logic [4:0] idx = 5'd0;
        for (int i = 0; i < 32; i++) if (g[i]) idx = i[4:0];
        return idx;
    endfunction

    task automatic drive(input logic rv, input logic [4:0] c, input logic rel,
                         input logic bl, input logic [31:0] mk_in);
        bus_if.req_valid_i  = rv;
        bus_if.req_code_i   = c;
        bus_if.release_i    = rel;
        bus_if.burst_load_i = bl;
        bus_if.burst_mask_i = mk_in;
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_eq({tag, "_grant"}, bus_if.grant_o, e.grant);
        check_eq({tag, "_code"},  {27'd0, bus_if.grant_code_o}, {27'd0, e.code});
        check_eq({tag, "_busy"},  {31'd0, bus_if.busy_o}, {31'd0, e.busy});
        check_eq({tag, "_done"},  {31'd0, bus_if.burst_done_o}, {31'd0, e.done});
        check_eq({tag, "_ready"}, {31'd0, bus_if.req_ready_o}, {31'd0, e.ready});
        check_eq({tag, "_onehot"}, ($countones(bus_if.grant_o) <= 1) ? 32'd1 : 32'd0, 32'd1);
        check_eq({tag, "_enc"}, {27'd0, bus_if.grant_code_o}, {27'd0, encode(bus_if.grant_o)});
    endtask

    task automatic cycle_exp(input exp_t e, input string tag);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare_out(tag);
    endtask

    task automatic take_lowest(output logic [31:0] g, output logic d);
        int idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_mask[i]) begin
                idx = i;
                break;
            end
        end
        g = 32'h1 << idx;
        m_mask[idx] = 1'b0;
        d = (m_mask == 32'h0);
    endtask

    task automatic model_step(input logic rv, input logic [4:0] c, input logic rel,
                              input logic bl, input logic [31:0] mk_in, output exp_t e);
        logic [31:0] g = 32'h0;
        logic        d = 1'b0;
        case (m_st)
            0: begin
                if (bl) begin
                    if (mk_in == 32'h0) d = 1'b1;
                    else begin
                        m_mask = mk_in;
                        m_st   = 3;
                        take_lowest(g, d);
                    end
                end else if (rv) begin
                    m_code = c;
                    m_st   = 1;
                end
            end
            1: begin
                if (rv && c != m_code) begin
                    m_code = c;
`ifdef BUS_GRANT_GAP_EN
                    m_st = 2;
`endif
                end else if (!rv && rel) begin
                    m_st = 0;
                end
            end
            2: m_st = 1;
            default: begin
                if (m_mask == 32'h0) m_st = 0;
                else take_lowest(g, d);
            end
        endcase
        if (m_st == 1) g = 32'h1 << m_code;
        e = mk(g, encode(g), m_st != 0, d, m_st <= 1);
    endtask

    initial begin
        clr = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_grant", bus_if.grant_o, 32'h0);
        check_eq("rst_code",  {27'd0, bus_if.grant_code_o}, 32'd0);
        check_eq("rst_ready", {31'd0, bus_if.req_ready_o}, 32'd1);
        check_eq("rst_busy",  {31'd0, bus_if.busy_o}, 32'd0);
        check_eq("rst_done",  {31'd0, bus_if.burst_done_o}, 32'd0);
        clr = 1'b0;
        cycle_exp(mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b1), "idle0");

        // single request then release
        drive(1'b1, 5'd7, 1'b0, 1'b0, 32'h0);
        cycle_exp(mk(32'h0000_0080, 5'd7, 1'b1, 1'b0, 1'b1), "req7");
        drive(1'b0, 5'd0, 1'b1, 1'b0, 32'h0);
        cycle_exp(mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b1), "rel7");

        // code switch 3 -> 31
        drive(1'b1, 5'd3, 1'b0, 1'b0, 32'h0);
        cycle_exp(mk(32'h0000_0008, 5'd3, 1'b1, 1'b0, 1'b1), "req3");
        drive(1'b1, 5'd31, 1'b0, 1'b0, 32'h0);
`ifdef BUS_GRANT_GAP_EN
        cycle_exp(mk(32'h0, 5'd0, 1'b1, 1'b0, 1'b0), "gap");
        idle_in();
`endif
        cycle_exp(mk(32'h8000_0000, 5'd31, 1'b1, 1'b0, 1'b1), "sw31");
        drive(1'b1, 5'd31, 1'b1, 1'b0, 32'h0);
        cycle_exp(mk(32'h8000_0000, 5'd31, 1'b1, 1'b0, 1'b1), "same_rel");
        drive(1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_00F0);
        cycle_exp(mk(32'h8000_0000, 5'd31, 1'b1, 1'b0, 1'b1), "bl_ignored");
        drive(1'b0, 5'd0, 1'b1, 1'b0, 32'h0);
        cycle_exp(mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b1), "rel31");

        // burst of three
        drive(1'b0, 5'd0, 1'b0, 1'b1, 32'h8000_0011);
        cycle_exp(mk(32'h0000_0001, 5'd0, 1'b1, 1'b0, 1'b0), "b1");
        idle_in();
        cycle_exp(mk(32'h0000_0010, 5'd4, 1'b1, 1'b0, 1'b0), "b2");
        cycle_exp(mk(32'h8000_0000, 5'd31, 1'b1, 1'b1, 1'b0), "b3");
        cycle_exp(mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b1), "b_end");

        // empty burst
        drive(1'b0, 5'd0, 1'b0, 1'b1, 32'h0);
        cycle_exp(mk(32'h0, 5'd0, 1'b0, 1'b1, 1'b1), "empty_done");
        idle_in();
        cycle_exp(mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b1), "empty_after");

        // burst beats simultaneous request
        drive(1'b1, 5'd9, 1'b0, 1'b1, 32'h0000_0006);
        cycle_exp(mk(32'h0000_0002, 5'd1, 1'b1, 1'b0, 1'b0), "pri1");
        idle_in();
        cycle_exp(mk(32'h0000_0004, 5'd2, 1'b1, 1'b1, 1'b0), "pri2");
        cycle_exp(mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b1), "pri_end");

        // clr during the second burst grant
        drive(1'b0, 5'd0, 1'b0, 1'b1, 32'h8000_0011);
        cycle_exp(mk(32'h0000_0001, 5'd0, 1'b1, 1'b0, 1'b0), "c1");
        idle_in();
        cycle_exp(mk(32'h0000_0010, 5'd4, 1'b1, 1'b0, 1'b0), "c2");
        clr = 1'b1;
        #1;
        check_eq("clr_grant", bus_if.grant_o, 32'h0);
        check_eq("clr_busy",  {31'd0, bus_if.busy_o}, 32'd0);
        check_eq("clr_done",  {31'd0, bus_if.burst_done_o}, 32'd0);
        check_eq("clr_ready", {31'd0, bus_if.req_ready_o}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 3; k++) cycle_exp(mk(32'h0, 5'd0, 1'b0, 1'b0, 1'b1), "post_clr");

        // randomised traffic against the reference model
        m_st = 0; m_code = 5'd0; m_mask = 32'h0;
        for (int k = 0; k < 400; k++) begin
            logic        rv, rel, bl;
            logic [4:0]  c;
            logic [31:0] mk_r;
            exp_t        e;
            rv  = ($urandom_range(0, 1) == 1);
            c   = 5'($urandom_range(0, 31));
            rel = ($urandom_range(0, 3) == 0);
            bl  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: mk_r = 32'h0;
                1: mk_r = 32'h1 << $urandom_range(0, 31);
                2: mk_r = $urandom() & $urandom() & $urandom();
                default: mk_r = $urandom();
            endcase
            drive(rv, c, rel, bl, mk_r);
            model_step(rv, c, rel, bl, mk_r, e);
            cycle_exp(e, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
